seq_detector: RTL and testbench

- Downstream consumer of the 12-bit LFSR serial stream.
- Detects the overlapping pattern 1011, MSB-first in arrival order, using a Moore FSM, and pulses `detect` on each hit.
- Counts hits and bits per LFSR period, using the LFSR's `max_tick` as the period boundary. Latches both totals at each boundary for the Sequence_Detector top level.

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_fsm.sv | 38 +++
 rtl/seq_detector.sv | 62 ++++++
 tb/tb_seq_detector.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the 1011 sequence detector: FSM state encoding,
// the detected pattern, and default counter widths.
package seq_det_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_1    = 3'd1,
      S_10   = 3'd2,
      S_101  = 3'd3,
      S_DET  = 3'd4
   } state_t;

   localparam logic [3:0] PATTERN   = 4'b1011;
   localparam int         CNT_W_DEF = 12;
   localparam int         LEN_W_DEF = 12;

endpackage

// File: rtl/seq_fsm.sv
// Moore FSM for the overlapping pattern 1011. detect is the registered S_DET
// state; hit is the combinational "entering S_DET this edge" flag.
module seq_fsm
   import seq_det_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic bit_in,
   output logic hit,
   output logic detect
);

   state_t r_state;
   state_t w_next;

   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      // NOTE: default assigned first so no path leaves w_next unassigned (no latch).
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:  w_next = bit_in ? S_1   : S_IDLE;
         S_1:     w_next = bit_in ? S_1   : S_10;
         S_10:    w_next = bit_in ? S_101 : S_IDLE;
         S_101:   w_next = bit_in ? S_DET : S_10;
         S_DET:   w_next = bit_in ? S_1   : S_10;
         default: w_next = S_IDLE;
      endcase
   end

   assign hit    = (w_next == S_DET);
   assign detect = (r_state == S_DET);

endmodule

// File: rtl/seq_detector.sv
// Pattern detector plus per-period hit and bit counters; both totals are
// latched and strobed whenever period_tick marks the first bit of a new period.
module seq_detector
   import seq_det_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bit_in,
   input  logic             period_tick,
   output logic             detect,
   output logic [CNT_W-1:0] count_out,
   output logic [LEN_W-1:0] period_len,
   output logic             count_valid
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [LEN_W-1:0] LEN_MAX = '1;

   logic             w_hit;
   logic [CNT_W-1:0] r_hit_cnt;
   logic [LEN_W-1:0] r_bit_cnt;
   logic [CNT_W-1:0] r_count_out;
   logic [LEN_W-1:0] r_period_len;
   logic             r_count_valid;

   seq_fsm u_fsm (
      .clk    (clk),
      .reset  (reset),
      .bit_in (bit_in),
      .hit    (w_hit),
      .detect (detect)
   );

   // The tick bit opens the new period, so a hit finishing on it is counted there.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hit_cnt     <= '0;
         r_bit_cnt     <= '0;
         r_count_out   <= '0;
         r_period_len  <= '0;
         r_count_valid <= 1'b0;
      end else if (period_tick) begin
         r_count_out   <= r_hit_cnt;
         r_period_len  <= r_bit_cnt;
         r_count_valid <= 1'b1;
         r_hit_cnt     <= CNT_W'(w_hit);
         r_bit_cnt     <= LEN_W'(1);
      end else begin
         r_count_valid <= 1'b0;
         if (w_hit && (r_hit_cnt != CNT_MAX)) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
         if (r_bit_cnt != LEN_MAX)            r_bit_cnt <= r_bit_cnt + LEN_W'(1);
      end
   end

   assign count_out   = r_count_out;
   assign period_len  = r_period_len;
   assign count_valid = r_count_valid;

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector: directed vector table, hand-written
// boundary sequences, random stimulus and a 3-period LFSR run, all against a
// sliding-window reference model. A narrow-width instance shares the stimulus.
module tb_seq_detector;
   import seq_det_pkg::*;

   localparam int CNT_W   = 12;
   localparam int LEN_W   = 12;
   localparam int S_CNT_W = 2;
   localparam int S_LEN_W = 4;
   localparam int LFSR_P  = 4095;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic bit_in = 1'b0;
   logic period_tick = 1'b0;

   logic               detect, count_valid;
   logic [CNT_W-1:0]   count_out;
   logic [LEN_W-1:0]   period_len;
   logic               s_detect, s_count_valid;
   logic [S_CNT_W-1:0] s_count_out;
   logic [S_LEN_W-1:0] s_period_len;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: last four bits since reset plus unbounded per-period counts.
   logic [3:0] m_hist;
   int         m_nbits, m_hits, m_bits, m_cnt_out, m_len_out;
   bit         m_det, m_valid;

   typedef struct {
      bit rst;
      bit b;
      bit t;
      bit det;
      bit vld;
      int cnt;
      int len;
   } vec_t;

   vec_t vecs[$];

   seq_detector #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset), .bit_in(bit_in), .period_tick(period_tick),
      .detect(detect), .count_out(count_out), .period_len(period_len),
      .count_valid(count_valid)
   );

   seq_detector #(.CNT_W(S_CNT_W), .LEN_W(S_LEN_W)) dut_small (
      .clk(clk), .reset(reset), .bit_in(bit_in), .period_tick(period_tick),
      .detect(s_detect), .count_out(s_count_out), .period_len(s_period_len),
      .count_valid(s_count_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input int exp);
      n_cmp++;
      if (act !== 32'(exp)) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_clear();
      m_hist = '0; m_nbits = 0; m_hits = 0; m_bits = 0;
      m_cnt_out = 0; m_len_out = 0; m_det = 0; m_valid = 0;
   endtask

   task automatic model_step(input bit b, input bit t);
      m_hist = {m_hist[2:0], b};
      m_nbits++;
      m_det = (m_nbits >= 4) && (m_hist == PATTERN);
      if (t) begin
         m_cnt_out = m_hits; m_len_out = m_bits; m_valid = 1;
         m_hits = int'(m_det); m_bits = 1;
      end else begin
         m_hits += int'(m_det); m_bits++; m_valid = 0;
      end
   endtask

   task automatic compare_all();
      check("detect",        32'(detect),        int'(m_det));
      check("count_valid",   32'(count_valid),   int'(m_valid));
      check("count_out",     32'(count_out),     sat(m_cnt_out, CNT_W));
      check("period_len",    32'(period_len),    sat(m_len_out, LEN_W));
      check("s_detect",      32'(s_detect),      int'(m_det));
      check("s_count_valid", 32'(s_count_valid), int'(m_valid));
      check("s_count_out",   32'(s_count_out),   sat(m_cnt_out, S_CNT_W));
      check("s_period_len",  32'(s_period_len),  sat(m_len_out, S_LEN_W));
   endtask

   // Drive one bit, let the edge sample it, then compare the registered outputs.
   task automatic cycle(input bit b, input bit t);
      bit_in = b; period_tick = t;
      @(posedge clk); #1;
      model_step(b, t);
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1'b1; bit_in = 1'b0; period_tick = 1'b0;
      #1;
      model_clear();
      compare_all();
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic push(input bit rst, input bit b, input bit t, input bit det,
                       input bit vld, input int cnt, input int len);
      vec_t v;
      v.rst = rst; v.b = b; v.t = t; v.det = det; v.vld = vld; v.cnt = cnt; v.len = len;
      vecs.push_back(v);
   endtask

   initial begin
      logic [11:0] lfsr;
      int          strobes;

      // Overlapping 1011011 then a tick; then 11001011 with no false hit on the 0,0 break.
      push(1, 1, 0, 0, 0, 0, 0); push(0, 0, 0, 0, 0, 0, 0); push(0, 1, 0, 0, 0, 0, 0);
      push(0, 1, 0, 1, 0, 0, 0); push(0, 0, 0, 0, 0, 0, 0); push(0, 1, 0, 0, 0, 0, 0);
      push(0, 1, 0, 1, 0, 0, 0); push(0, 0, 1, 0, 1, 2, 7);
      push(1, 1, 0, 0, 0, 0, 0); push(0, 1, 0, 0, 0, 0, 0); push(0, 0, 0, 0, 0, 0, 0);
      push(0, 0, 0, 0, 0, 0, 0); push(0, 1, 0, 0, 0, 0, 0); push(0, 0, 0, 0, 0, 0, 0);
      push(0, 1, 0, 0, 0, 0, 0); push(0, 1, 0, 1, 0, 0, 0); push(0, 0, 1, 0, 1, 1, 8);

      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset();
         cycle(vecs[i].b, vecs[i].t);
         check($sformatf("vec%0d_detect", i), 32'(detect), int'(vecs[i].det));
         check($sformatf("vec%0d_valid", i), 32'(count_valid), int'(vecs[i].vld));
         check($sformatf("vec%0d_count", i), 32'(count_out), vecs[i].cnt);
         check($sformatf("vec%0d_len", i), 32'(period_len), vecs[i].len);
      end

      // Hit completing on the tick bit after three prior hits.
      do_reset();
      foreach (PATTERN[i]) cycle(PATTERN[i], 1'b0);
      for (int k = 0; k < 2; k++) begin
         cycle(1'b0, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
      end
      cycle(1'b0, 1'b0); cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b1);
      check("tick_hit_detect", 32'(detect), 1);
      check("tick_hit_valid", 32'(count_valid), 1);
      check("tick_hit_count", 32'(count_out), 3);
      check("tick_hit_len", 32'(period_len), 12);
      cycle(1'b0, 1'b0);
      check("tick_hit_valid_drop", 32'(count_valid), 0);
      cycle(1'b0, 1'b0); cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      check("next_period_count", 32'(count_out), 1);
      check("next_period_len", 32'(period_len), 4);
      cycle(1'b0, 1'b1);
      check("b2b_tick_valid", 32'(count_valid), 1);
      check("b2b_tick_len", 32'(period_len), 1);
      check("b2b_tick_count", 32'(count_out), 0);

      // Reset mid-pattern discards the partial match.
      do_reset();
      cycle(1'b1, 1'b0); cycle(1'b0, 1'b0); cycle(1'b1, 1'b0);
      do_reset();
      check("reset_count", 32'(count_out), 0);
      check("reset_len", 32'(period_len), 0);
      cycle(1'b1, 1'b0);
      check("reset_no_detect", 32'(detect), 0);
      cycle(1'b0, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
      check("reset_fresh_detect", 32'(detect), 1);

      // Five hits in 20 bits: narrow instance saturates both totals.
      do_reset();
      cycle(1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
      end
      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      check("sat_small_count", 32'(s_count_out), 3);
      check("sat_small_len", 32'(s_period_len), 15);
      check("sat_wide_count", 32'(count_out), 5);
      check("sat_wide_len", 32'(period_len), 20);

      // Random bits, sparse ticks, occasional asynchronous reset.
      do_reset();
      for (int k = 0; k < 2000; k++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
      end

      // Three periods of a maximal-length 12-bit LFSR (x^12+x^6+x^4+x+1).
      do_reset();
      lfsr = 12'h001;
      strobes = 0;
      for (int k = 0; k <= 3 * LFSR_P; k++) begin
         cycle(lfsr[11], (k > 0) && (k % LFSR_P == 0));
         if (count_valid) begin
            strobes++;
            check("lfsr_strobe_time", 32'(k), strobes * LFSR_P);
            check("lfsr_period_len", 32'(period_len), LFSR_P);
            if (strobes >= 2) check("lfsr_count", 32'(count_out), 256);
         end
         lfsr = {lfsr[10:0], lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0]};
      end
      check("lfsr_strobes", 32'(strobes), 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
